// File: rtl/ha_row_seq_mul_pkg.sv
// Shared types for the sequential half-adder-row approximate multiplier:
// column compression modes, FSM states and the row-group count.
package ha_seq_pkg;

    typedef enum logic [1:0] {
        MODE_HA     = 2'b00,
        MODE_OR     = 2'b01,
        MODE_ACARRY = 2'b10,
        MODE_ELIM   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int W_DEF  = 8;
    localparam int GROUPS = W_DEF / 2;

    function automatic int groups_of(input int w);
        return w / 2;
    endfunction

endpackage

// File: rtl/ha_row_seq_mul_row_group.sv
// One row group: compresses the two partial-product rows selected by a pair
// of x bits into a sum vector plus a carry vector, column by column.
module ha_row_group
    import ha_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]       y,
    input  logic [1:0]         xb,
    input  logic [2*(W-1)-1:0] modes,
    output logic [W+1:0]       grp_val
);

    logic [W-1:0] a;
    logic [W-1:0] c;
    logic [W+1:0] sum_v;
    logic [W+1:0] car_v;

    assign a = y & {W{xb[0]}};
    assign c = y & {W{xb[1]}};

    // Column j pairs a_j with c_{j-1}; a carry lands at weight j+1.
    always_comb begin
        sum_v    = '0;
        car_v    = '0;
        sum_v[0] = a[0];
        sum_v[W] = c[W-1];
        for (int j = 1; j < W; j++) begin
            case (mode_e'(modes[2*j-2 +: 2]))
                MODE_HA: begin
                    sum_v[j]   = a[j] ^ c[j-1];
                    car_v[j+1] = a[j] & c[j-1];
                end
                MODE_OR:     sum_v[j]   = a[j] | c[j-1];
                MODE_ACARRY: car_v[j+1] = a[j];
                default: ;
            endcase
        end
    end

    assign grp_val = sum_v + car_v;

endmodule

// File: rtl/ha_row_seq_mul.sv
// Sequential W x W approximate multiplier: one row-group compressor reused
// for each x-bit pair, accumulated into a 2W-bit product.
module ha_row_seq_mul
    import ha_seq_pkg::*;
#(
    parameter int         W       = 8,
    parameter logic [1:0] CFG_RST = 2'b00
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             x,
    input  logic [W-1:0]             y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*W-1:0]           p,
    input  logic                     cfg_we,
    output logic                     cfg_ready,
    input  logic [$clog2(W/2)-1:0]   cfg_grp,
    input  logic [2*(W-1)-1:0]       cfg_data,
    output logic                     busy
);

    localparam int NG = groups_of(W);
    localparam int CW = $clog2(NG);
    localparam int MW = 2 * (W - 1);

    state_e          state;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  acc;
    logic [W-1:0]    x_r;
    logic [W-1:0]    y_r;
    logic [MW-1:0]   modes [NG];

    logic [1:0]      xb;
    logic [W+1:0]    grp_val;
    logic [2*W-1:0]  addend;
    logic [2*W-1:0]  acc_nxt;

    assign xb      = 2'(x_r >> {cnt, 1'b0});
    assign addend  = (2*W)'(grp_val) << {cnt, 1'b0};
    assign acc_nxt = acc + addend;

    ha_row_group #(.W(W)) u_grp (
        .y       (y_r),
        .xb      (xb),
        .modes   (modes[cnt]),
        .grp_val (grp_val)
    );

    assign in_ready  = (state == IDLE);
    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            x_r       <= '0;
            y_r       <= '0;
            p         <= '0;
            out_valid <= 1'b0;
            for (int g = 0; g < NG; g++) begin
                modes[g] <= {(W-1){CFG_RST}};
            end
        end else begin
            // Mode writes land on the same edge as an accept, so the new
            // operand is compressed with the freshly written modes.
            if (cfg_we && state == IDLE) begin
                modes[cfg_grp] <= cfg_data;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_r   <= x;
                        y_r   <= y;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(NG - 1)) begin
                        p         <= acc_nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ha_row_seq_mul.sv
// Self-checking bench for ha_row_seq_mul: exact-product table, mode
// programming, output stall, mid-run reset and back-to-back operation.
module tb_ha_row_seq_mul;

    localparam int W  = 8;
    localparam int NG = 4;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    x;
    logic [W-1:0]    y;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  p;
    logic            cfg_we;
    logic            cfg_ready;
    logic [1:0]      cfg_grp;
    logic [13:0]     cfg_data;
    logic            busy;

    ha_row_seq_mul #(.W(W), .CFG_RST(2'b00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .cfg_we    (cfg_we),
        .cfg_ready (cfg_ready),
        .cfg_grp   (cfg_grp),
        .cfg_data  (cfg_data),
        .busy      (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

    typedef struct {
        logic [7:0]  vx;
        logic [7:0]  vy;
        logic [15:0] vp;
    } vec_t;

    vec_t tbl [8];

    logic [2*W-1:0] exp_q [$];
    int             acc_q [$];
    int             rise_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // scoreboard monitor: latency on out_valid rise, product on handshake
    logic prev_ov = 1'b0;
    int   lat_a;
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (out_valid && !prev_ov) begin
                rise_q.push_back(cyc);
                if (acc_q.size() == 0) chk("latency_no_accept", 1, 0);
                else begin
                    lat_a = acc_q.pop_front();
                    chk("latency", cyc - lat_a, NG);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_product", 1, 0);
                else chk("product", int'(p), int'(exp_q.pop_front()));
            end
        end
        prev_ov = out_valid;
    end

    // driver tasks
    task automatic issue(input logic [7:0] vx, input logic [7:0] vy,
                         input logic [15:0] vp, input bit keep);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        x        = vx;
        y        = vy;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            exp_q.push_back(vp);
            acc_q.push_back(cyc + 1);
        end
        @(posedge clk);
        if (!keep) begin
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic do_cfg(input logic [1:0] grp, input logic [13:0] data, output logic rdy);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_grp  = grp;
        cfg_data = data;
        #1;
        rdy = cfg_ready;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((busy || exp_q.size() != 0) && n < 100);
        if (n >= 100) chk("drain_timeout", 0, 1);
    endtask

    logic       rdy;
    logic [7:0] rx;
    logic [7:0] ry;

    initial begin
        tbl[0] = '{8'd13,  8'd11,  16'd143};
        tbl[1] = '{8'd255, 8'd255, 16'd65025};
        tbl[2] = '{8'd0,   8'd0,   16'd0};
        tbl[3] = '{8'd1,   8'd255, 16'd255};
        tbl[4] = '{8'd255, 8'd1,   16'd255};
        tbl[5] = '{8'd170, 8'd85,  16'd14450};
        tbl[6] = '{8'd128, 8'd128, 16'd16384};
        tbl[7] = '{8'd200, 8'd3,   16'd600};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        x         = '0;
        y         = '0;
        out_ready = 1'b1;
        cfg_we    = 1'b0;
        cfg_grp   = '0;
        cfg_data  = '0;

        #12;
        chk("rst_p", int'(p), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // exact-mode table
        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].vx, tbl[i].vy, tbl[i].vp, 1'b0);
            wait_idle();
        end

        // random exact products
        for (int i = 0; i < 4; i++) begin
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(0, 255));
            issue(rx, ry, 16'(rx) * 16'(ry), 1'b0);
            wait_idle();
        end

        // group 0 column 1: OR, back to HA, eliminate
        do_cfg(2'd0, 14'h0001, rdy);
        chk("cfg_ready_or", int'(rdy), 1);
        issue(8'd3, 8'd3, 16'd7, 1'b0);
        wait_idle();
        do_cfg(2'd0, 14'h0000, rdy);
        issue(8'd3, 8'd3, 16'd9, 1'b0);
        wait_idle();
        do_cfg(2'd0, 14'h0003, rdy);
        issue(8'd1, 8'd3, 16'd1, 1'b0);
        wait_idle();

        // write and accept in the same cycle: OR mode applies to this operand
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_grp  = 2'd0;
        cfg_data = 14'h0001;
        in_valid = 1'b1;
        x        = 8'd3;
        y        = 8'd3;
        #1;
        exp_q.push_back(16'd7);
        acc_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        wait_idle();
        do_cfg(2'd0, 14'h0000, rdy);

        // output stall with a dropped config write
        out_ready = 1'b0;
        issue(8'd13, 8'd11, 16'd143, 1'b0);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        chk("stall_reach_done", int'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) begin
                cfg_we   = 1'b1;
                cfg_grp  = 2'd0;
                cfg_data = 14'h0003;
            end else begin
                cfg_we = 1'b0;
            end
            #1;
            chk("stall_p", int'(p), 143);
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_in_ready", int'(in_ready), 0);
            if (i == 3) chk("stall_cfg_ready", int'(cfg_ready), 0);
        end
        @(negedge clk);
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        issue(8'd1, 8'd3, 16'd3, 1'b0);
        wait_idle();

        // reset in the middle of RUN, with non-exact modes loaded
        do_cfg(2'd0, 14'h1555, rdy);
        do_cfg(2'd1, 14'h3FFF, rdy);
        issue(8'd7, 8'd9, 16'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_reset_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_p", int'(p), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_cfg_ready", int'(cfg_ready), 1);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'd7, 8'd9, 16'd63, 1'b0);
        wait_idle();

        // back-to-back: in_valid and out_ready held high
        rise_q.delete();
        for (int i = 0; i < 3; i++) begin
            rx = 8'($urandom_range(1, 255));
            ry = 8'($urandom_range(1, 255));
            issue(rx, ry, 16'(rx) * 16'(ry), (i < 2));
        end
        wait_idle();
        chk("b2b_count", rise_q.size(), 3);
        // handshake edge, then one IDLE cycle before the next accept
        if (rise_q.size() == 3) begin
            chk("b2b_spacing_1", rise_q[1] - rise_q[0], NG + 2);
            chk("b2b_spacing_2", rise_q[2] - rise_q[1], NG + 2);
        end

        chk("exp_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
